img_stream_src: RTL and testbench

- Frame reader that produces the pixel stream consumed by the team's valid/ready/eot stream FIFOs, i.e. the writer side of that interface.
- On a start pulse, it reads one IMG_W x IMG_H frame, row-major, from a synchronous single-port RAM with 1-cycle read latency.
- It emits each pixel on a valid/ready stream, tagged with eot[0] (end of row) and eot[1] (end of frame).
- A 2-entry output buffer absorbs RAM latency so backpressure never loses data; sustained throughput is 1 pixel/cycle.

---
 rtl/img_stream_src.sv | 163 ++++++++++++++++
 tb/tb_img_stream_src.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_src.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : img_stream_src
// Description : Reads one IMG_W x IMG_H frame from a 1-cycle-latency RAM and
//               emits it on a valid/ready stream tagged with row/frame eot.
// Revision    : 1.0  initial release
// ============================================================================
module img_stream_src #(
  parameter int W_DATA = 8,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int W_ADDR = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [W_ADDR-1:0] mem_addr,
  input  logic [W_DATA-1:0] mem_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic [1:0]        dout_eot
);

  localparam int c_W_X = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_W_Y = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [c_W_X-1:0]  c_X_LAST   = c_W_X'(IMG_W-1);
  localparam logic [c_W_Y-1:0]  c_Y_LAST   = c_W_Y'(IMG_H-1);
  localparam logic [W_ADDR-1:0] c_ADDR_ONE = W_ADDR'(1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_RUN   = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [c_W_X-1:0]  r_x;
  logic [c_W_Y-1:0]  r_y;
  logic [W_ADDR-1:0] r_addr;
  logic              r_inflight;
  logic [1:0]        r_inflight_eot;

  logic [W_DATA-1:0] r_buf_data [0:1];
  logic [1:0]        r_buf_eot  [0:1];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;

  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic              w_x_last;
  logic              w_y_last;
  logic [1:0]        w_eot_issue;

  assign dout_valid  = (r_occ != 2'd0);
  assign dout_data   = r_buf_data[r_rptr];
  assign dout_eot    = r_buf_eot[r_rptr];
  assign mem_addr    = r_addr;

  assign w_pop       = dout_valid & dout_ready;
  assign w_push      = r_inflight;
  assign w_x_last    = (r_x == c_X_LAST);
  assign w_y_last    = (r_y == c_Y_LAST);
  assign w_eot_issue = {w_x_last & w_y_last, w_x_last};

  // occ + inflight - pop < 2, rearranged to stay non-negative
  assign w_room = (({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (start) w_state_nxt = c_S_RUN;
      c_S_RUN:   if (mem_rd && w_x_last && w_y_last) w_state_nxt = c_S_DRAIN;
      // the final pixel is the only entry left once it is being popped
      c_S_DRAIN: if (w_pop && (r_occ == 2'd1) && !r_inflight && dout_eot[1])
                   w_state_nxt = c_S_DONE;
      c_S_DONE:  w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      c_S_IDLE:  busy = 1'b0;
      c_S_RUN:   begin busy = 1'b1; mem_rd = w_room; end
      c_S_DRAIN: busy = 1'b1;
      c_S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x            <= '0;
      r_y            <= '0;
      r_addr         <= '0;
      r_inflight     <= 1'b0;
      r_inflight_eot <= 2'b00;
    end else begin
      r_inflight     <= mem_rd;
      r_inflight_eot <= w_eot_issue;
      if (r_state == c_S_IDLE && start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end else if (mem_rd) begin
        r_addr <= r_addr + c_ADDR_ONE;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= r_y + c_W_Y'(1);
        end else begin
          r_x <= r_x + c_W_X'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_eot[0]  <= 2'b00;
      r_buf_eot[1]  <= 2'b00;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_occ         <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wptr] <= mem_data;
        r_buf_eot[r_wptr]  <= r_inflight_eot;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_stream_src.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_img_stream_src
// Description : Directed self-checking bench for img_stream_src (4x3 frame).
// Revision    : 1.0  initial release
// ============================================================================
module tb_img_stream_src;
  localparam int W_DATA = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int W_ADDR = 4;
  localparam int N_PX   = 12;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [W_ADDR-1:0] mem_addr;
  logic [W_DATA-1:0] mem_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [W_DATA-1:0] dout_data;
  logic [1:0]        dout_eot;

  img_stream_src #(.W_DATA(W_DATA), .IMG_W(IMG_W), .IMG_H(IMG_H), .W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_eot(dout_eot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: RAM[i] = i + 16
  always @(posedge clk) begin
    if (mem_rd) mem_data <= 8'(mem_addr) + 8'd16;
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [7:0] px_d [0:15];
  logic [1:0] px_e [0:15];
  int n_px, n_rd, n_done, first_v, last_hs, first_rd, first_rd_addr, done_c;
  int inv_err, stab_err, outst, timed_out;
  int busy_at_done, busy_after1, busy_after2, rd_after2;
  int hold_rd, hold_v, hold_d;
  int ab_v, ab_busy, ab_rd, ab_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      2:       return (c >= 10);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_frame(input int mode, input bit extra, input int abort_n,
                           input bit pre_started, input bit chain);
    int pv_v, pv_r, ab, pop;
    logic [7:0] pv_d;
    logic [1:0] pv_e;
    n_px = 0; n_rd = 0; n_done = 0; first_v = -1; last_hs = -1; first_rd = -1;
    first_rd_addr = -1; done_c = -1; inv_err = 0; stab_err = 0; outst = 0;
    timed_out = 1; busy_at_done = -1; busy_after1 = -1; busy_after2 = -1;
    rd_after2 = -1; hold_rd = -1; hold_v = -1; hold_d = -1;
    pv_v = 0; pv_r = 1; pv_d = '0; pv_e = '0; ab = 0;
    if (!pre_started) begin
      step();
      start = 1'b1;
      dout_ready = rdy(mode, 0);
      @(negedge clk);
    end
    for (int c = 1; c <= 200; c++) begin
      step();
      start = 1'b0;
      if (extra && (c == 7 || c == 8 || c == 15)) start = 1'b1;
      dout_ready = rdy(mode, c);
      if (abort_n != 0 && ab == 0 && n_px == abort_n) begin
        rst = 1'b1; ab = 1;
      end else if (ab == 1) begin
        rst = 1'b0; ab = 2;
      end
      if (chain && done_c >= 0 && c == done_c + 1) start = 1'b1;
      @(negedge clk);
      if (ab == 2) begin
        ab_v = dout_valid; ab_busy = busy; ab_rd = mem_rd; ab_done = done;
        timed_out = 0;
        break;
      end
      if (!rst) begin
        pop = (dout_valid && dout_ready) ? 1 : 0;
        if (mem_rd) begin
          if (first_rd < 0) begin first_rd = c; first_rd_addr = int'(mem_addr); end
          n_rd++;
        end
        if (mem_rd && (outst - pop) >= 2) inv_err++;
        if (outst > 2) inv_err++;
        outst = outst + (mem_rd ? 1 : 0) - pop;
        if (pv_v != 0 && pv_r == 0 &&
            (!dout_valid || dout_data !== pv_d || dout_eot !== pv_e)) stab_err++;
        pv_v = dout_valid; pv_r = dout_ready; pv_d = dout_data; pv_e = dout_eot;
        if (dout_valid && first_v < 0) first_v = c;
        if (pop != 0) begin
          if (n_px < 16) begin px_d[n_px] = dout_data; px_e[n_px] = dout_eot; end
          n_px++;
          last_hs = c;
        end
        if (done) begin
          n_done++;
          if (done_c < 0) begin done_c = c; busy_at_done = busy; end
        end
        if (mode == 2 && c == 9) begin
          hold_rd = n_rd; hold_v = dout_valid; hold_d = dout_data;
        end
        if (done_c >= 0 && c == done_c + 1) begin
          busy_after1 = busy;
          if (chain) begin timed_out = 0; break; end
        end
        if (done_c >= 0 && c == done_c + 2) begin
          busy_after2 = busy; rd_after2 = mem_rd; timed_out = 0;
          break;
        end
      end
    end
  endtask

  task automatic frame_checks(input string tag);
    logic [1:0] e;
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_npx"}, n_px, N_PX);
    for (int i = 0; i < N_PX; i++) begin
      e = (i == N_PX - 1) ? 2'b11 : ((i % IMG_W) == IMG_W - 1) ? 2'b01 : 2'b00;
      chk($sformatf("%s_data%0d", tag, i), px_d[i], 16 + i);
      chk($sformatf("%s_eot%0d", tag, i), px_e[i], e);
    end
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_occ_rule"}, inv_err, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dout_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_data", dout_data, 0);
    chk("rst_eot", dout_eot, 0);
    step();
    rst = 1'b0;
    @(negedge clk);

    // full-rate frame with latency checks
    run_frame(0, 0, 0, 0, 0);
    frame_checks("f1");
    chk("f1_first_rd", first_rd, 1);
    chk("f1_first_addr", first_rd_addr, 0);
    chk("f1_first_valid", first_v, 3);
    chk("f1_last_hs", last_hs, 14);
    chk("f1_done_cyc", done_c, 15);
    chk("f1_busy_done", busy_at_done, 1);
    chk("f1_busy_after", busy_after1, 0);

    // ready pattern 1,0,0,1
    run_frame(1, 0, 0, 0, 0);
    frame_checks("toggle");

    // ready low for the first 10 cycles
    run_frame(2, 0, 0, 0, 0);
    frame_checks("hold");
    chk("hold_reads", hold_rd, 2);
    chk("hold_valid", hold_v, 1);
    chk("hold_data", hold_d, 16);

    // extra start pulses while busy and in the done cycle
    run_frame(0, 1, 0, 0, 0);
    frame_checks("restart");
    chk("restart_done_cyc", done_c, 15);
    chk("restart_idle_busy", busy_after2, 0);
    chk("restart_idle_rd", rd_after2, 0);

    // reset after the 6th handshake
    run_frame(0, 0, 6, 0, 0);
    chk("abort_timeout", timed_out, 0);
    chk("abort_npx", n_px, 6);
    chk("abort_px5", px_d[5], 21);
    chk("abort_valid", ab_v, 0);
    chk("abort_busy", ab_busy, 0);
    chk("abort_mem_rd", ab_rd, 0);
    chk("abort_done", ab_done, 0);
    run_frame(0, 0, 0, 0, 0);
    frame_checks("post_rst");

    // back-to-back frames: start in the cycle after done
    run_frame(0, 0, 0, 0, 1);
    frame_checks("b2b_a");
    chk("b2b_a_idle_busy", busy_after1, 0);
    run_frame(0, 0, 0, 1, 0);
    frame_checks("b2b_b");
    chk("b2b_b_first_rd", first_rd, 1);
    chk("b2b_b_done_cyc", done_c, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
